// File: rtl/coreriscv_axi4_debug_bus_target_if.sv
// Debug bus request/response channels between the JTAG DTM and the core-side target.
interface coreriscv_axi4_debug_bus_target_if #(
    parameter int unsigned DEBUG_DATA_BITS = 34,
    parameter int unsigned DEBUG_ADDR_BITS = 5,
    parameter int unsigned DEBUG_OP_BITS   = 2
);
    localparam int unsigned REQ_BITS  = DEBUG_OP_BITS + DEBUG_ADDR_BITS + DEBUG_DATA_BITS;
    localparam int unsigned RESP_BITS = DEBUG_OP_BITS + DEBUG_DATA_BITS;

    // Request is packed {addr, data, op}; response is packed {data, resp}.
    logic                 dtm_req_valid;
    logic                 dtm_req_ready;
    logic [REQ_BITS-1:0]  dtm_req_data;
    logic                 dtm_resp_valid;
    logic                 dtm_resp_ready;
    logic [RESP_BITS-1:0] dtm_resp_data;

    modport master (
        output dtm_req_valid,
        output dtm_req_data,
        output dtm_resp_ready,
        input  dtm_req_ready,
        input  dtm_resp_valid,
        input  dtm_resp_data
    );

    modport slave (
        input  dtm_req_valid,
        input  dtm_req_data,
        input  dtm_resp_ready,
        output dtm_req_ready,
        output dtm_resp_valid,
        output dtm_resp_data
    );
endinterface

// File: rtl/coreriscv_axi4_debug_bus_target.sv
// Core-side debug bus target: executes one dbus request at a time against the
// debug RAM and the interrupt/haltnot status bits, and gives the hart a RAM port.
module coreriscv_axi4_debug_bus_target #(
    parameter int unsigned DEBUG_DATA_BITS = 34,
    parameter int unsigned DEBUG_ADDR_BITS = 5,
    parameter int unsigned DEBUG_OP_BITS   = 2,
    parameter int unsigned DRAM_WORDS      = 16
) (
    input  logic                              CLK,
    input  logic                              RESETN,
    coreriscv_axi4_debug_bus_target_if.slave  bus,
    input  logic [$clog2(DRAM_WORDS)-1:0]     hart_ram_addr,
    input  logic                              hart_ram_we,
    input  logic [DEBUG_DATA_BITS-3:0]        hart_ram_wdata,
    output logic [DEBUG_DATA_BITS-3:0]        hart_ram_rdata,
    input  logic                              hart_halt_notify,
    input  logic                              hart_clear_int,
    output logic                              debug_int
);
    localparam int unsigned WORD_BITS = DEBUG_DATA_BITS - 2;
    localparam int unsigned RAM_AW    = $clog2(DRAM_WORDS);
    localparam int unsigned RESP_BITS = DEBUG_OP_BITS + DEBUG_DATA_BITS;

    localparam logic [DEBUG_OP_BITS-1:0] OP_NOP    = DEBUG_OP_BITS'(0);
    localparam logic [DEBUG_OP_BITS-1:0] OP_READ   = DEBUG_OP_BITS'(1);
    localparam logic [DEBUG_OP_BITS-1:0] OP_WRITE  = DEBUG_OP_BITS'(2);
    localparam logic [DEBUG_OP_BITS-1:0] RESP_OK   = DEBUG_OP_BITS'(0);
    localparam logic [DEBUG_OP_BITS-1:0] RESP_FAIL = DEBUG_OP_BITS'(2);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                     state_q;
    state_t                     state_d;
    logic                       req_ready_q;
    logic                       req_ready_d;
    logic                       resp_valid_q;
    logic                       resp_valid_d;
    logic [RESP_BITS-1:0]       resp_data_q;
    logic [RESP_BITS-1:0]       resp_data_d;
    logic                       req_accept;

    logic [DEBUG_OP_BITS-1:0]   op_q;
    logic [DEBUG_ADDR_BITS-1:0] addr_q;
    logic [DEBUG_DATA_BITS-1:0] data_q;

    logic                       interrupt_q;
    logic                       interrupt_d;
    logic                       haltnot_q;
    logic                       haltnot_d;

    logic                       exec_write;
    logic                       in_range;
    logic [RAM_AW-1:0]          ram_idx;
    logic [WORD_BITS-1:0]       ram_word;
    logic [DEBUG_DATA_BITS-1:0] exec_data;
    logic [DEBUG_OP_BITS-1:0]   exec_resp;

    logic [WORD_BITS-1:0]       ram [DRAM_WORDS];

    assign exec_write         = (state_q == EXEC) && (op_q == OP_WRITE);
    assign debug_int          = interrupt_q;
    assign bus.dtm_req_ready  = req_ready_q;
    assign bus.dtm_resp_valid = resp_valid_q;
    assign bus.dtm_resp_data  = resp_data_q;

    // Access decode and status update; set requests win over same-cycle clears.
    always_comb begin
        in_range    = 32'(addr_q) < DRAM_WORDS;
        ram_idx     = addr_q[RAM_AW-1:0];
        ram_word    = in_range ? ram[ram_idx] : '0;
        interrupt_d = interrupt_q;
        haltnot_d   = haltnot_q;
        exec_resp   = RESP_OK;
        exec_data   = '0;

        if (hart_clear_int) begin
            interrupt_d = 1'b0;
        end
        if (exec_write && data_q[DEBUG_DATA_BITS-1]) begin
            interrupt_d = 1'b1;
        end
        if (exec_write && !data_q[DEBUG_DATA_BITS-2]) begin
            haltnot_d = 1'b0;
        end
        if (hart_halt_notify) begin
            haltnot_d = 1'b1;
        end

        case (op_q)
            OP_READ:  exec_data = {interrupt_q, haltnot_q, ram_word};
            OP_WRITE: exec_data = {interrupt_d, haltnot_d, data_q[WORD_BITS-1:0]};
            OP_NOP:   exec_data = {interrupt_q, haltnot_q, WORD_BITS'(0)};
            default:  exec_resp = RESP_FAIL;
        endcase
    end

    // Transaction FSM; the response is loaded in EXEC and presented one edge later.
    always_comb begin
        state_d      = state_q;
        req_ready_d  = 1'b0;
        resp_valid_d = resp_valid_q;
        resp_data_d  = resp_data_q;
        req_accept   = 1'b0;

        unique case (state_q)
            IDLE: begin
                req_accept = bus.dtm_req_valid && req_ready_q;
                if (req_accept) begin
                    state_d = EXEC;
                end
            end
            EXEC: begin
                resp_data_d = {exec_data, exec_resp};
                state_d     = RESP;
            end
            RESP: begin
                if (!resp_valid_q) begin
                    resp_valid_d = 1'b1;
                end else if (bus.dtm_resp_ready) begin
                    resp_valid_d = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        req_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state_q      <= IDLE;
            req_ready_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            interrupt_q  <= 1'b0;
            haltnot_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            interrupt_q  <= interrupt_d;
            haltnot_q    <= haltnot_d;
        end
    end

    // Request capture on handshake.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            op_q   <= '0;
            addr_q <= '0;
            data_q <= '0;
        end else if (req_accept) begin
            {addr_q, data_q, op_q} <= bus.dtm_req_data;
        end
    end

    // Debug RAM has no reset; the later dbus write wins a same-word collision.
    always_ff @(posedge CLK) begin
        if (hart_ram_we) begin
            ram[hart_ram_addr] <= hart_ram_wdata;
        end
        if (exec_write && in_range) begin
            ram[ram_idx] <= data_q[WORD_BITS-1:0];
        end
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            hart_ram_rdata <= '0;
        end else begin
            hart_ram_rdata <= ram[hart_ram_addr];
        end
    end
endmodule
